// File: rtl/bcd_accum_scan_if.sv
// Command/display bundle for the BCD accumulator: the controller drives commands,
// the accumulator returns the count, the overflow flags and the scanned display lines.
interface bcd_accum_scan_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned VW = 4 * DIGITS;

  logic              clr;
  logic              load;
  logic [VW-1:0]     load_val;
  logic              inc;
  logic [VW-1:0]     step;
  logic              blank_lz;
  logic [VW-1:0]     value;
  logic              carry;
  logic              ovf;
  logic [6:0]        seg;
  logic [DIGITS-1:0] dig_sel;

  modport master (
    output clr, load, load_val, inc, step, blank_lz,
    input  value, carry, ovf, seg, dig_sel
  );

  modport slave (
    input  clr, load, load_val, inc, step, blank_lz,
    output value, carry, ovf, seg, dig_sel
  );
endinterface

// File: rtl/bcd_accum_scan.sv
// N-digit BCD accumulator (wrap or saturate on overflow) with a multiplexed
// active-low seven-segment scan driver and optional leading-zero blanking.
module bcd_accum_scan #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned SATURATE = 0
) (
  input logic             clk,
  input logic             rst_n,
  bcd_accum_scan_if.slave bus
);
  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [VW-1:0] ALL_NINES = {DIGITS{4'h9}};
  localparam logic [6:0]    SEG_ZERO  = 7'b1000000;
  localparam logic [6:0]    SEG_BLANK = 7'b1111111;

  logic [VW-1:0]     value_q;
  logic              carry_q;
  logic              ovf_q;
  logic [PW-1:0]     presc_q;
  logic [IW-1:0]     idx_q;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] dig_sel_q;

  logic [VW-1:0]     step_sat;
  logic [VW-1:0]     load_fix;
  logic [VW-1:0]     sum_val;
  logic [4:0]        dsum;
  logic              rc;
  logic              carry_top;

  logic [3:0]        cur_digit;
  logic              upper_nz;
  logic [DIGITS-1:0] sel_oh;
  logic [6:0]        seg_nxt;

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Operand sanitising and single-cycle ripple BCD add.
  always_comb begin
    step_sat  = '0;
    load_fix  = '0;
    sum_val   = '0;
    dsum      = '0;
    rc        = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      step_sat[4*i +: 4] = (bus.step[4*i +: 4] > 4'd9) ? 4'd9 : bus.step[4*i +: 4];
      load_fix[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd0 : bus.load_val[4*i +: 4];
      dsum = 5'(value_q[4*i +: 4]) + 5'(step_sat[4*i +: 4]) + 5'(rc);
      if (dsum > 5'd9) begin
        sum_val[4*i +: 4] = 4'(dsum - 5'd10);
        rc                = 1'b1;
      end else begin
        sum_val[4*i +: 4] = dsum[3:0];
        rc                = 1'b0;
      end
    end
    carry_top = rc;
  end

  // Count register: clr beats load beats inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.clr) begin
      value_q <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.load) begin
      value_q <= load_fix;
      carry_q <= 1'b0;
    end else if (bus.inc) begin
      carry_q <= carry_top;
      if (carry_top) begin
        ovf_q <= 1'b1;
      end
      value_q <= (carry_top && (SATURATE != 0)) ? ALL_NINES : sum_val;
    end else begin
      carry_q <= 1'b0;
    end
  end

  // Scan prescaler and digit index; independent of the count commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Select the active digit and decide blanking from it and everything above it.
  always_comb begin
    cur_digit = '0;
    upper_nz  = 1'b0;
    sel_oh    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        cur_digit = value_q[4*i +: 4];
        sel_oh[i] = 1'b1;
      end
      if ((IW'(i) >= idx_q) && (value_q[4*i +: 4] != 4'd0)) begin
        upper_nz = 1'b1;
      end
    end
    if (bus.blank_lz && (idx_q != '0) && !upper_nz) begin
      seg_nxt = SEG_BLANK;
    end else begin
      seg_nxt = seg7(cur_digit);
    end
  end

  // seg and dig_sel register together so they always describe the same digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q     <= SEG_ZERO;
      dig_sel_q <= DIGITS'(1);
    end else begin
      seg_q     <= seg_nxt;
      dig_sel_q <= sel_oh;
    end
  end

  assign bus.value   = value_q;
  assign bus.carry   = carry_q;
  assign bus.ovf     = ovf_q;
  assign bus.seg     = seg_q;
  assign bus.dig_sel = dig_sel_q;

endmodule

// File: tb/tb_bcd_accum_scan.sv
// Bench for bcd_accum_scan: a wrapping and a saturating instance share stimulus;
// an integer-arithmetic model feeds a scoreboard, scan/decode checked per scenario.
module tb_bcd_accum_scan;
  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 2;

  typedef struct packed {
    logic [15:0] v;
    logic        c;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_accum_scan_if #(.DIGITS(DIGITS)) bw ();
  bcd_accum_scan_if #(.DIGITS(DIGITS)) bs ();

  bcd_accum_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bw.slave));
  bcd_accum_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(bs.slave));

  exp_t q_w[$];
  exp_t q_s[$];
  int   checks = 0;
  int   errors = 0;
  int   m_val[2];
  bit   m_ovf[2];

  function automatic int bcd2int(input logic [15:0] b, input bit hi_to_nine);
    int n = 0;
    for (int i = 3; i >= 0; i--) begin
      int d = int'(b[4*i +: 4]);
      if (d > 9) d = hi_to_nine ? 9 : 0;
      n = n * 10 + d;
    end
    return n;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r = '0;
    int k = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(k % 10);
      k = k / 10;
    end
    return r;
  endfunction

  // Mode 0 wraps, mode 1 saturates.
  function automatic exp_t model(input int m, input bit c, input bit l, input logic [15:0] lv,
                                 input bit i, input logic [15:0] st);
    exp_t e;
    int   s;
    e.c = 1'b0;
    if (c) begin
      m_val[m] = 0;
      m_ovf[m] = 1'b0;
    end else if (l) begin
      m_val[m] = bcd2int(lv, 1'b0);
    end else if (i) begin
      s = m_val[m] + bcd2int(st, 1'b1);
      if (s > 9999) begin
        e.c = 1'b1;
        m_ovf[m] = 1'b1;
        s = (m == 1) ? 9999 : s - 10000;
      end
      m_val[m] = s;
    end
    e.v = int2bcd(m_val[m]);
    e.o = m_ovf[m];
    return e;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int idx, input bit blank);
    logic [3:0] d;
    logic [15:0] upper;
    upper = v >> (4 * idx);
    if (blank && idx != 0 && upper == 16'h0) return 7'b1111111;
    d = v[4*idx +: 4];
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0011000;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  // Drive one command cycle on both instances and queue the model's prediction.
  task automatic apply(input bit c, input bit l, input logic [15:0] lv, input bit i,
                       input logic [15:0] st);
    bw.clr = c; bw.load = l; bw.load_val = lv; bw.inc = i; bw.step = st;
    bs.clr = c; bs.load = l; bs.load_val = lv; bs.inc = i; bs.step = st;
    q_w.push_back(model(0, c, l, lv, i, st));
    q_s.push_back(model(1, c, l, lv, i, st));
    @(posedge clk);
    #2;
    bw.clr = 0; bw.load = 0; bw.inc = 0;
    bs.clr = 0; bs.load = 0; bs.inc = 0;
  endtask

  // Scoreboard: compare both instances one delta-safe step after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q_w.size() > 0) begin
      e = q_w.pop_front();
      checks++;
      if (bw.value !== e.v) begin errors++; $display("FAIL wrap_value: got %h want %h", bw.value, e.v); end
      checks++;
      if (bw.carry !== e.c) begin errors++; $display("FAIL wrap_carry: got %b want %b", bw.carry, e.c); end
      checks++;
      if (bw.ovf !== e.o) begin errors++; $display("FAIL wrap_ovf: got %b want %b", bw.ovf, e.o); end
    end
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      checks++;
      if (bs.value !== e.v) begin errors++; $display("FAIL sat_value: got %h want %h", bs.value, e.v); end
      checks++;
      if (bs.carry !== e.c) begin errors++; $display("FAIL sat_carry: got %b want %b", bs.carry, e.c); end
      checks++;
      if (bs.ovf !== e.o) begin errors++; $display("FAIL sat_ovf: got %b want %b", bs.ovf, e.o); end
    end
  end

  task automatic test_reset_values(input string tag);
    checks++;
    if (bw.value !== 16'h0 || bs.value !== 16'h0) begin
      errors++; $display("FAIL %s_value: got %h/%h want 0000", tag, bw.value, bs.value);
    end
    checks++;
    if (bw.carry !== 1'b0 || bw.ovf !== 1'b0 || bs.carry !== 1'b0 || bs.ovf !== 1'b0) begin
      errors++; $display("FAIL %s_flags: got c%b o%b / c%b o%b want zeros", tag, bw.carry, bw.ovf, bs.carry, bs.ovf);
    end
    checks++;
    if (bw.dig_sel !== 4'b0001 || bs.dig_sel !== 4'b0001) begin
      errors++; $display("FAIL %s_dig_sel: got %b/%b want 0001", tag, bw.dig_sel, bs.dig_sel);
    end
    checks++;
    if (bw.seg !== 7'b1000000 || bs.seg !== 7'b1000000) begin
      errors++; $display("FAIL %s_seg: got %b/%b want 1000000", tag, bw.seg, bs.seg);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_sel [6];
    exp_sel[0] = 4'b0001; exp_sel[1] = 4'b0001; exp_sel[2] = 4'b0010;
    exp_sel[3] = 4'b0010; exp_sel[4] = 4'b0100; exp_sel[5] = 4'b0100;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    test_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bw.dig_sel !== exp_sel[k]) begin
        errors++; $display("FAIL scan_step%0d: got %b want %b", k, bw.dig_sel, exp_sel[k]);
      end
    end
    #1;
  endtask

  task automatic test_wrap_overflow();
    apply(1, 0, 16'h0, 0, 16'h0);
    apply(0, 1, 16'h9995, 0, 16'h0);
    apply(0, 0, 16'h0, 1, 16'h0007);
    apply(0, 0, 16'h0, 0, 16'h0);
    apply(0, 0, 16'h0, 1, 16'h0007);
  endtask

  task automatic test_saturate();
    apply(1, 0, 16'h0, 0, 16'h0);
    apply(0, 1, 16'h9990, 0, 16'h0);
    apply(0, 0, 16'h0, 1, 16'h0025);
    apply(0, 0, 16'h0, 1, 16'h0025);
    apply(0, 0, 16'h0, 0, 16'h0);
  endtask

  task automatic test_digit_clamp();
    apply(0, 1, 16'hA3F7, 0, 16'h0);
    apply(1, 0, 16'h0, 0, 16'h0);
    apply(0, 0, 16'h0, 1, 16'h000C);
  endtask

  task automatic test_priority();
    apply(0, 1, 16'h9999, 0, 16'h0);
    apply(0, 0, 16'h0, 1, 16'h0001);
    apply(1, 1, 16'h5555, 1, 16'h0001);
    apply(0, 1, 16'h1234, 1, 16'h0001);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 24; k++) begin
      if (k % 7 == 3) apply(0, 1, 16'($urandom), 1, 16'($urandom));
      else            apply(0, 0, 16'h0, 1, 16'($urandom));
    end
  endtask

  task automatic test_blank(input bit blank);
    int         idx;
    logic [3:0] seen = '0;
    bw.blank_lz = blank;
    bs.blank_lz = blank;
    @(posedge clk);
    #2;
    for (int k = 0; k < 2 * SCAN_DIV * DIGITS; k++) begin
      @(posedge clk);
      #1;
      idx = -1;
      for (int j = 0; j < 4; j++) if (bw.dig_sel[j]) idx = j;
      checks++;
      if (!$onehot(bw.dig_sel)) begin
        errors++; $display("FAIL blank%0d_onehot: got %b want one-hot", blank, bw.dig_sel);
      end else begin
        seen[idx] = 1'b1;
        checks++;
        if (bw.seg !== exp_seg(16'h0040, idx, blank)) begin
          errors++; $display("FAIL blank%0d_seg_d%0d: got %b want %b", blank, idx, bw.seg, exp_seg(16'h0040, idx, blank));
        end
      end
    end
    checks++;
    if (seen !== 4'b1111) begin
      errors++; $display("FAIL blank%0d_frame: digits seen %b want 1111", blank, seen);
    end
    #1;
  endtask

  task automatic test_mid_reset();
    apply(0, 1, 16'h0040, 0, 16'h0);
    bw.blank_lz = 1'b1;
    bs.blank_lz = 1'b1;
    test_blank(1'b1);
    test_blank(1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    m_val[0] = 0; m_val[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
    #1;
    test_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 0, 16'h0, 1, 16'h0321);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bw.clr = 0; bw.load = 0; bw.load_val = '0; bw.inc = 0; bw.step = '0; bw.blank_lz = 0;
    bs.clr = 0; bs.load = 0; bs.load_val = '0; bs.inc = 0; bs.step = '0; bs.blank_lz = 0;
    m_val[0] = 0; m_val[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
    test_reset();
    test_wrap_overflow();
    test_saturate();
    test_digit_clamp();
    test_priority();
    test_back_to_back();
    test_mid_reset();
    @(posedge clk);
    #3;
    checks++;
    if (q_w.size() != 0 || q_s.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d/%0d entries left", q_w.size(), q_s.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
